// File: rtl/passcode_entry_pkg.sv
// Shared alarm-system types: the alarm FSM state seen by passcode_entry and
// the entry FSM state encoding.
package passcode_entry_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE    = 2'd0,
    STATE_SET     = 2'd1,
    STATE_TRIGGER = 2'd2,
    STATE_ALERT   = 2'd3
  } fsm_state_t;

  typedef enum logic [2:0] {
    E_OFF     = 3'd0,
    E_COLLECT = 3'd1,
    E_CHECK   = 3'd2,
    E_MATCH   = 3'd3,
    E_LOCKED  = 3'd4
  } entry_state_t;

  // Code entry is only meaningful while the alarm is set or already triggered.
  function automatic logic is_armed(input fsm_state_t s);
    return (s == STATE_SET) || (s == STATE_TRIGGER);
  endfunction

endpackage

// File: rtl/passcode_entry_if.sv
// Bus between the board/alarm FSM (master) and passcode_entry (slave).
interface passcode_entry_if #(
  parameter int DIGIT_W = 4
) ();
  import passcode_entry_pkg::*;

  logic               btn2;
  logic [DIGIT_W-1:0] sw_digit;
  fsm_state_t         system_state;
  logic               passcode_correct;
  logic               passcode_wrong;
  logic [2:0]         digit_count;
  logic               locked;

  modport master (
    output btn2, sw_digit, system_state,
    input  passcode_correct, passcode_wrong, digit_count, locked
  );

  modport slave (
    input  btn2, sw_digit, system_state,
    output passcode_correct, passcode_wrong, digit_count, locked
  );

endinterface

// File: rtl/passcode_entry_btn_debounce.sv
// Active-low push-button conditioner: 2-FF synchroniser, stability counter and
// a one-cycle pulse on each debounced press (1->0 transition).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // Idle level is released (high) so reset never produces a spurious press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/passcode_entry.sv
// Passcode entry stage of the alarm: collects digits, compares with CODE and
// reports correct/wrong. Define PASSCODE_LOCKOUT_EN to enable the wrong-attempt lockout.
module passcode_entry
  import passcode_entry_pkg::*;
#(
  parameter int NUM_DIGITS      = 4,
  parameter int DIGIT_W         = 4,
  parameter logic [NUM_DIGITS*DIGIT_W-1:0] CODE = 16'h1234,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int MAX_ATTEMPTS    = 3,
  parameter int LOCKOUT_CYCLES  = 500000000
) (
  input  logic clk,
  input  logic rst,
  passcode_entry_if.slave bus
);

  localparam int BW = NUM_DIGITS * DIGIT_W;

  localparam logic [2:0] ST_OFF     = E_OFF;
  localparam logic [2:0] ST_COLLECT = E_COLLECT;
  localparam logic [2:0] ST_CHECK   = E_CHECK;
  localparam logic [2:0] ST_MATCH   = E_MATCH;
  localparam logic [2:0] ST_LOCKED  = E_LOCKED;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 7 || MAX_ATTEMPTS < 1 || LOCKOUT_CYCLES < 1) begin : g_param_check
    $error("passcode_entry: parameter out of range");
  end

  logic          press;
  logic          armed;
  logic          state_chg;
  logic          check_ok;
  logic          check_bad;
  logic          lock_hit;
  logic          lock_done;
  logic [2:0]    state_q;
  logic [BW-1:0] buffer_q;
  logic [2:0]    count_q;
  logic          wrong_q;
  fsm_state_t    prev_state_q;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn2_debounce (
    .clk  (clk),
    .rst  (rst),
    .btn_n(bus.btn2),
    .press(press)
  );

  assign armed     = is_armed(bus.system_state);
  assign state_chg = (bus.system_state != prev_state_q);
  assign check_ok  = (state_q == ST_CHECK) && armed && !state_chg && (buffer_q == CODE);
  assign check_bad = (state_q == ST_CHECK) && armed && !state_chg && (buffer_q != CODE);

  // A lockout ignores arming and state changes; every other state is flushed by them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_OFF;
      buffer_q     <= '0;
      count_q      <= '0;
      wrong_q      <= 1'b0;
      prev_state_q <= STATE_IDLE;
    end else begin
      prev_state_q <= bus.system_state;
      wrong_q      <= 1'b0;
      if (state_q == ST_LOCKED) begin
        if (lock_done) state_q <= armed ? ST_COLLECT : ST_OFF;
      end else if (!armed || state_chg) begin
        state_q  <= ST_OFF;
        buffer_q <= '0;
        count_q  <= '0;
      end else begin
        case (state_q)
          ST_OFF: state_q <= ST_COLLECT;
          ST_COLLECT: begin
            if (press) begin
              buffer_q <= BW'({buffer_q, bus.sw_digit});
              count_q  <= count_q + 3'd1;
              if (count_q == 3'(NUM_DIGITS - 1)) state_q <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (check_ok) begin
              state_q <= ST_MATCH;
            end else begin
              buffer_q <= '0;
              count_q  <= '0;
              wrong_q  <= 1'b1;
              state_q  <= lock_hit ? ST_LOCKED : ST_COLLECT;
            end
          end
          ST_MATCH: state_q <= ST_MATCH;
          default:  state_q <= ST_OFF;
        endcase
      end
    end
  end

`ifdef PASSCODE_LOCKOUT_EN
  localparam int AW = $clog2(MAX_ATTEMPTS + 1);
  localparam int TW = $clog2(LOCKOUT_CYCLES + 1);

  logic [AW-1:0] attempts_q;
  logic [TW-1:0] lock_timer_q;

  assign lock_hit  = (attempts_q == AW'(MAX_ATTEMPTS - 1));
  assign lock_done = (state_q == ST_LOCKED) && (lock_timer_q == TW'(LOCKOUT_CYCLES - 1));

  // Attempts and timer deliberately survive alarm state changes; only rst clears them early.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      attempts_q   <= '0;
      lock_timer_q <= '0;
    end else begin
      if (check_ok || lock_done) attempts_q <= '0;
      else if (check_bad)        attempts_q <= attempts_q + AW'(1);
      if (state_q == ST_LOCKED && !lock_done) lock_timer_q <= lock_timer_q + TW'(1);
      else                                    lock_timer_q <= '0;
    end
  end

  assign bus.locked = (state_q == ST_LOCKED);
`else
  assign lock_hit   = 1'b0;
  assign lock_done  = 1'b0;
  assign bus.locked = 1'b0;
`endif

  assign bus.passcode_correct = (state_q == ST_MATCH);
  assign bus.passcode_wrong   = wrong_q;
  assign bus.digit_count      = count_q;

endmodule
